// File: rtl/irq_ctrl.sv
// irq_ctrl: edge/level interrupt controller with claim/complete over a native one-access-at-a-time bus
module irq_ctrl #(
  parameter int NUM_IRQ = 32,
  parameter int ADDR_W  = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               nmi_valid_i,
  input  logic [31:0]        nmi_addr_i,
  input  logic [31:0]        nmi_wdata_i,
  input  logic [3:0]         nmi_wstrb_i,
  output logic               nmi_ready_o,
  output logic [31:0]        nmi_rdata_o,
  output logic               irq_o
);
  typedef enum logic {IDLE, ACK} state_t;
  localparam logic [ADDR_W-3:0] OFF_PEND  = (ADDR_W-2)'(0);
  localparam logic [ADDR_W-3:0] OFF_EN    = (ADDR_W-2)'(1);
  localparam logic [ADDR_W-3:0] OFF_TRIG  = (ADDR_W-2)'(2);
  localparam logic [ADDR_W-3:0] OFF_CLAIM = (ADDR_W-2)'(3);
  localparam logic [ADDR_W-3:0] OFF_SRV   = (ADDR_W-2)'(4);
  state_t state_q, state_d;
  logic [NUM_IRQ-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d, enable_q, enable_d, trig_q, trig_d, insrv_q, insrv_d;
  logic [NUM_IRQ-1:0] elig, rise, clr, set_srv, clr_srv, bm, wd;
  logic [31:0] rdata_q, rdata_d, bmask;
  logic irq_q, irq_d, accept, wr, rd_en;
  logic [ADDR_W-3:0] off;
  logic [5:0] claim_id;
  always_comb begin
    accept   = state_q == IDLE && nmi_valid_i;
    wr       = accept && |nmi_wstrb_i;
    rd_en    = accept && ~|nmi_wstrb_i;
    off      = nmi_addr_i[ADDR_W-1:2];
    bmask    = {{8{nmi_wstrb_i[3]}}, {8{nmi_wstrb_i[2]}}, {8{nmi_wstrb_i[1]}}, {8{nmi_wstrb_i[0]}}};
    bm       = bmask[NUM_IRQ-1:0];
    wd       = nmi_wdata_i[NUM_IRQ-1:0] & bm;
    elig     = pend_q & enable_q & ~insrv_q;
    rise     = sync2_q & ~sync3_q;
    claim_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (elig[i]) claim_id = 6'(i + 1);
    for (int i = 0; i < NUM_IRQ; i++) begin
      set_srv[i] = rd_en && off == OFF_CLAIM && claim_id == 6'(i + 1);
      clr_srv[i] = wr && off == OFF_CLAIM && nmi_wstrb_i[0] && nmi_wdata_i[5:0] == 6'(i + 1) && insrv_q[i];
    end
    enable_d = (wr && off == OFF_EN) ? (enable_q & ~bm) | wd : enable_q;
    trig_d   = (wr && off == OFF_TRIG) ? (trig_q & ~bm) | wd : trig_q;
    insrv_d  = (insrv_q | set_srv) & ~clr_srv;
    clr      = ((wr && off == OFF_PEND) ? wd : '0) | set_srv;
    // a line just switched to edge mode starts clean; a fresh rising edge beats any clear
    for (int i = 0; i < NUM_IRQ; i++)
      pend_d[i] = !trig_d[i] ? sync2_q[i] : !trig_q[i] ? 1'b0 : rise[i] | (pend_q[i] & ~clr[i]);
    irq_d    = |(pend_d & enable_d & ~insrv_d);
    rdata_d  = !rd_en              ? '0 :
               off == OFF_PEND     ? 32'(pend_q) :
               off == OFF_EN       ? 32'(enable_q) :
               off == OFF_TRIG     ? 32'(trig_q) :
               off == OFF_CLAIM    ? 32'(claim_id) :
               off == OFF_SRV      ? 32'(insrv_q) : '0;
    state_d  = accept ? ACK : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      sync1_q  <= '0;
      sync2_q  <= '0;
      sync3_q  <= '0;
      pend_q   <= '0;
      enable_q <= '0;
      trig_q   <= '0;
      insrv_q  <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= irq_i;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      pend_q   <= pend_d;
      enable_q <= enable_d;
      trig_q   <= trig_d;
      insrv_q  <= insrv_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end
  // reset raised during the ACK cycle suppresses the pending ready pulse
  assign nmi_ready_o = state_q == ACK && !rst_i;
  assign nmi_rdata_o = rdata_q;
  assign irq_o       = irq_q;
endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL provide parameter NUM_IRQ, default 32, number of interrupt lines (1..32).
REQ-002 SHALL provide parameter ADDR_W, default 5, number of register-offset bits decoded from nmi_addr_i.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk_i  in  1  system clock.
REQ-005 SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have port irq_i  in  NUM_IRQ  raw interrupt lines from the SoC irq vector (asynchronous allowed).
REQ-007 SHALL have port nmi_valid_i  in  1  native bus request valid.
REQ-008 SHALL have port nmi_addr_i  in  32  byte address; only bits [ADDR_W-1:2] are decoded.
REQ-009 SHALL have port nmi_wdata_i  in  32  write data.
REQ-010 SHALL have port nmi_wstrb_i  in  4  byte strobes; nonzero means write, zero means read.
REQ-011 SHALL have port nmi_ready_o  out  1  one-cycle transfer-complete pulse.
REQ-012 SHALL have port nmi_rdata_o  out  32  read data, valid while nmi_ready_o is high.
REQ-013 SHALL have port irq_o  out  1  registered interrupt request to the core.

Function
REQ-014 SHALL pass each irq_i bit through two flops (sync1, sync2), plus a third flop (sync3) for edge detect.
REQ-015 SHALL hold the registers PEND at 0x00, ENABLE at 0x04, TRIG at 0x08, CLAIM at 0x0C and INSRV at 0x10.
REQ-016 PEND SHALL be read-only in level lines; for edge lines, a write-1 to a PEND bit clears it.
REQ-017 ENABLE and TRIG SHALL be read/write; a TRIG bit of 1 selects rising-edge trigger and 0 selects level trigger.
REQ-018 INSRV SHALL be read-only.
REQ-019 Unmapped offsets SHALL read 0 and ignore writes; bits at or above NUM_IRQ SHALL read 0.
REQ-020 Edge line: PEND[i] SHALL be set when sync2 & ~sync3, and cleared by W1C or by a claim of line i.
REQ-021 If a set and a clear of the same PEND bit occur in the same cycle, the set SHALL win.
REQ-022 Level line: PEND[i] SHALL load sync2[i] every cycle; W1C and claim SHALL have no effect on it.
REQ-023 The eligibility vector SHALL be E = PEND & ENABLE & ~INSRV.
REQ-024 irq_o SHALL be registered as |E.
REQ-025 irq_o SHALL assert 3 clock edges after the first edge that samples irq_i high, provided the line is enabled and idle.
REQ-026 A CLAIM read SHALL return id = (lowest-index set bit of E) + 1, or 0 if E is empty.
REQ-027 In the same cycle, a CLAIM read SHALL set INSRV[id-1] and clear PEND[id-1] for an edge line; id 0 SHALL change nothing.
REQ-028 A CLAIM write of wdata[5:0] = id with INSRV[id-1] set SHALL clear INSRV[id-1] (complete).
REQ-029 A CLAIM write with id 0, id > NUM_IRQ, or a line that is not in service SHALL be ignored.
REQ-030 Bus handshake: the block SHALL register the request when nmi_valid_i is high and no access is in flight.
REQ-031 nmi_ready_o SHALL pulse high for exactly 1 cycle on the following cycle, carrying rdata; the master holds valid until ready.
REQ-032 The block SHALL NOT accept a new access in the cycle nmi_ready_o is high, giving a 2-cycle minimum spacing.
REQ-033 Bus FSM SHALL have states IDLE -> ACK on valid; ACK -> IDLE unconditionally.
REQ-034 Register side effects (W1C, claim, complete, ENABLE/TRIG update) SHALL occur on the IDLE->ACK edge.
REQ-035 Write data SHALL honour byte strobes for ENABLE, TRIG and PEND; CLAIM SHALL use wdata[5:0] whenever wstrb[0] is set.
REQ-036 A TRIG change SHALL take effect next cycle; switching edge->level SHALL reload PEND from sync2; switching level->edge SHALL clear PEND[i].
REQ-037 Disabling a line SHALL not clear PEND or INSRV; irq_o SHALL drop within 1 cycle if no other line is eligible.

Reset
REQ-038 While rst_i is high at a clock edge, sync1/2/3, PEND, ENABLE, TRIG, INSRV, the FSM (IDLE), nmi_ready_o, nmi_rdata_o and irq_o SHALL all become 0.
REQ-039 A bus access in flight when rst_i asserts SHALL be dropped with no ready pulse and no side effect.
REQ-040 Edges on irq_i during reset SHALL be lost; a line held high through reset release SHALL be seen as an edge 2 cycles later.

Verification
REQ-041 Bench SHALL cover: ENABLE=0x1, TRIG=0x1, pulse irq_i[0] for 1 cycle -> irq_o high 3 edges later; CLAIM read returns 1; irq_o low next cycle; INSRV=0x1; CLAIM write 1 -> INSRV=0.
REQ-042 Bench SHALL cover: ENABLE=0x30, lines 4 and 5 pending -> CLAIM reads 5, then 6, then 0; INSRV=0x30.
REQ-043 Bench SHALL cover: level line 2 held high, claimed and completed -> irq_o re-asserts 1 cycle after completion; deassert irq_i[2] -> PEND[2]=0 after 3 edges.
REQ-044 Bench SHALL cover: edge on line 3 coincident with W1C of PEND bit 3 -> PEND[3] remains 1.
REQ-045 Bench SHALL cover: CLAIM write of 0, 33, or a non-in-service id -> no register change; read of 0x14 -> 0x00000000 with a 1-cycle ready pulse.
REQ-046 Bench SHALL cover: rst_i asserted during ACK -> no ready pulse; all registers read 0 after release.
